resp_demux_ot: RTL and testbench

- Parametrised successor of the single-entry response demultiplexer for a TCDM slave port.
- Tracks up to MAX_OUTSTANDING granted read requests in an in-order FIFO of master indices.
- Routes each slave response (rdata/rvalid/rready handshake) back to the master that issued the oldest outstanding read.
- Raises a stall flag to the arbiter when the tracker is full, and sticky error flags on overflow or underflow.

---
 rtl/resp_demux_ot.sv | 103 ++++++++++
 tb/tb_resp_demux_ot.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/resp_demux_ot.sv
// Response demultiplexer for a TCDM slave port. Tracks granted reads in an
// in-order FIFO of master indices and routes each response to the oldest one.
module resp_demux_ot #(
  parameter int unsigned NUM_OUTPUTS     = 4,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned IDX_W          = $clog2(NUM_OUTPUTS),
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              req_i,
  input  logic                              gnt_i,
  input  logic [IDX_W-1:0]                  master_idx_i,
  input  logic [NUM_OUTPUTS-1:0]            wen_i,
  input  logic [DATA_WIDTH-1:0]             rdata_i,
  input  logic                              rvalid_i,
  output logic                              rready_o,
  input  logic [NUM_OUTPUTS-1:0]            rready_i,
  output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] rdata_o,
  output logic [NUM_OUTPUTS-1:0]            rvalid_o,
  output logic                              stall_o,
  output logic                              empty_o,
  output logic [CNT_W-1:0]                  outstanding_o,
  output logic                              overflow_o,
  output logic                              underflow_o,
  input  logic                              clear_err_i
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [IDX_W-1:0] idx_mem_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q, underflow_q;

  logic             empty, full, push_req, push, pop;
  logic [IDX_W-1:0] head;

  // Wrap at the configured depth, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign head     = idx_mem_q[rd_ptr_q];
  assign push_req = req_i & gnt_i & ~wen_i[master_idx_i];
  assign pop      = rvalid_i & rready_o & ~empty;
  // At full a push is only accepted when the head retires in the same cycle.
  assign push     = push_req & (~full | pop);

  // Route the response to the head master; stray responses are sunk.
  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    rready_o = 1'b1;
    if (!empty) begin
      rvalid_o[head]                                  = rvalid_i;
      rdata_o[32'(head) * DATA_WIDTH +: DATA_WIDTH] = rdata_i;
      rready_o                                        = rready_i[head];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (clear_err_i) begin
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end else begin
        if (push_req & full & ~pop) overflow_q  <= 1'b1;
        if (rvalid_i & empty)       underflow_q <= 1'b1;
      end
    end
  end

  // Index storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk_i) begin
    if (push) idx_mem_q[wr_ptr_q] <= master_idx_i;
  end

  assign stall_o       = full;
  assign empty_o       = empty;
  assign outstanding_o = count_q;
  assign overflow_o    = overflow_q;
  assign underflow_o   = underflow_q;

endmodule

// File: tb/tb_resp_demux_ot.sv
// Bench for resp_demux_ot: depth-4 and depth-3 instances share stimulus and are
// compared every cycle against a queue-based model of grant-order routing.
module tb_resp_demux_ot;

  logic         clk_i = 1'b0;
  logic         reset_i, req_i, gnt_i, rvalid_i, clear_err_i;
  logic [1:0]   master_idx_i;
  logic [3:0]   wen_i, rready_i;
  logic [31:0]  rdata_i;

  logic         rready4, stall4, empty4, ovf4, unf4;
  logic [127:0] rdata4;
  logic [3:0]   rvalid4;
  logic [2:0]   outst4;

  logic         rready3, stall3, empty3, ovf3, unf3;
  logic [127:0] rdata3;
  logic [3:0]   rvalid3;
  logic [1:0]   outst3;

  int errors = 0;
  int checks = 0;

  // Model state: [0] = depth-4 instance, [1] = depth-3 instance.
  int mq [2][$];
  int mdepth [2] = '{4, 3};
  bit mov [2];
  bit mun [2];

  always #5 clk_i = ~clk_i;

  resp_demux_ot #(.NUM_OUTPUTS(4), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)) dut4 (
    .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .gnt_i(gnt_i),
    .master_idx_i(master_idx_i), .wen_i(wen_i), .rdata_i(rdata_i),
    .rvalid_i(rvalid_i), .rready_o(rready4), .rready_i(rready_i),
    .rdata_o(rdata4), .rvalid_o(rvalid4), .stall_o(stall4), .empty_o(empty4),
    .outstanding_o(outst4), .overflow_o(ovf4), .underflow_o(unf4),
    .clear_err_i(clear_err_i));

  resp_demux_ot #(.NUM_OUTPUTS(4), .DATA_WIDTH(32), .MAX_OUTSTANDING(3)) dut3 (
    .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .gnt_i(gnt_i),
    .master_idx_i(master_idx_i), .wen_i(wen_i), .rdata_i(rdata_i),
    .rvalid_i(rvalid_i), .rready_o(rready3), .rready_i(rready_i),
    .rdata_o(rdata3), .rvalid_o(rvalid3), .stall_o(stall3), .empty_o(empty3),
    .outstanding_o(outst3), .overflow_o(ovf3), .underflow_o(unf3),
    .clear_err_i(clear_err_i));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow directly from the oldest outstanding master.
  task automatic check_dut(input int s, input string n, input logic ro, input logic [3:0] rv,
                           input logic [127:0] rd, input logic st, input logic em,
                           input logic [2:0] oc, input logic of, input logic uf);
    logic [3:0]   e_rv = '0;
    logic [127:0] e_rd = '0;
    logic         e_ro = 1'b1;
    int           sz   = mq[s].size();
    if (sz > 0) begin
      e_rv[mq[s][0]]          = rvalid_i;
      e_rd[mq[s][0]*32 +: 32] = rdata_i;
      e_ro                    = rready_i[mq[s][0]];
    end
    check({n, "_rvalid"}, 128'(rv), 128'(e_rv));
    check({n, "_rdata"}, rd, e_rd);
    check({n, "_rready"}, 128'(ro), 128'(e_ro));
    check({n, "_stall"}, 128'(st), 128'(sz == mdepth[s]));
    check({n, "_empty"}, 128'(em), 128'(sz == 0));
    check({n, "_outstanding"}, 128'(oc), 128'(sz));
    check({n, "_overflow"}, 128'(of), 128'(mov[s]));
    check({n, "_underflow"}, 128'(uf), 128'(mun[s]));
  endtask

  task automatic model_step(input int s);
    int  sz;
    bit  rdy, pop, preq;
    sz = mq[s].size();
    if (reset_i) begin
      mq[s].delete();
      mov[s] = 1'b0;
      mun[s] = 1'b0;
      return;
    end
    rdy  = (sz == 0) ? 1'b1 : rready_i[mq[s][0]];
    pop  = rvalid_i && rdy && (sz > 0);
    preq = req_i && gnt_i && !wen_i[master_idx_i];
    if (clear_err_i) begin
      mov[s] = 1'b0;
      mun[s] = 1'b0;
    end else begin
      if (preq && sz == mdepth[s] && !pop) mov[s] = 1'b1;
      if (rvalid_i && sz == 0)             mun[s] = 1'b1;
    end
    if (pop) void'(mq[s].pop_front());
    if (preq && (sz < mdepth[s] || pop)) mq[s].push_back(int'(master_idx_i));
  endtask

  // Called just after a rising edge with inputs already applied.
  task automatic cycle();
    #1;
    check_dut(0, "d4", rready4, rvalid4, rdata4, stall4, empty4, outst4, ovf4, unf4);
    check_dut(1, "d3", rready3, rvalid3, rdata3, stall3, empty3, 3'(outst3), ovf3, unf3);
    @(posedge clk_i);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic idle();
    reset_i = 0; req_i = 0; gnt_i = 0; master_idx_i = 0; wen_i = 0;
    rvalid_i = 0; rdata_i = 0; rready_i = 4'hF; clear_err_i = 0;
  endtask

  task automatic push_rd(input int m);
    idle(); req_i = 1; gnt_i = 1; master_idx_i = 2'(m);
  endtask

  task automatic resp(input logic [31:0] d);
    idle(); rvalid_i = 1; rdata_i = d;
  endtask

  initial begin
    idle();
    reset_i = 1;
    repeat (2) @(posedge clk_i);
    for (int s = 0; s < 2; s++) model_step(s);
    #1;
    idle();
    cycle();

    // Single read from master 2
    push_rd(2); cycle();
    resp(32'hDEADBEEF); #1;
    check("single_rvalid", 128'(rvalid4), 128'(4'b0100));
    check("single_lane2", 128'(rdata4[95:64]), 128'(32'hDEADBEEF));
    cycle();
    idle(); #1;
    check("single_empty_after", 128'(empty4), 128'(1'b1));
    cycle();

    // Fill: 3,1,0,2 then drain in order
    push_rd(3); cycle(); push_rd(1); cycle(); push_rd(0); cycle(); push_rd(2); cycle();
    idle(); #1;
    check("fill_stall", 128'(stall4), 128'(1'b1));
    check("fill_outstanding", 128'(outst4), 128'(3'd4));
    for (int i = 0; i < 4; i++) begin resp(32'h10 + 32'(i)); cycle(); end
    idle(); clear_err_i = 1; cycle();

    // Push and pop at full, then overflow and clear
    push_rd(3); cycle(); push_rd(1); cycle(); push_rd(0); cycle(); push_rd(2); cycle();
    push_rd(1); rvalid_i = 1; rdata_i = 32'h20; cycle();
    idle(); #1;
    check("fullpp_count", 128'(outst4), 128'(3'd4));
    check("fullpp_no_ovf", 128'(ovf4), 128'(1'b0));
    push_rd(3); cycle();
    idle(); #1;
    check("ovf_set", 128'(ovf4), 128'(1'b1));
    clear_err_i = 1; cycle();
    idle(); #1;
    check("ovf_cleared", 128'(ovf4), 128'(1'b0));
    for (int i = 0; i < 4; i++) begin resp(32'h30 + 32'(i)); cycle(); end

    // Backpressure on head master 0
    push_rd(0); cycle();
    for (int i = 0; i < 3; i++) begin
      resp(32'h55); rready_i = 4'b1110; #1;
      check("bp_rready_low", 128'(rready4), 128'(1'b0));
      cycle();
    end
    resp(32'h55); cycle();
    idle(); #1;
    check("bp_popped", 128'(empty4), 128'(1'b1));

    // Write filtering, stray response, clear
    push_rd(1); wen_i = 4'b0010; cycle();
    resp(32'h77); #1;
    check("stray_rvalid", 128'(rvalid4), 128'(4'b0000));
    check("stray_rready", 128'(rready4), 128'(1'b1));
    cycle();
    idle(); #1;
    check("unf_set", 128'(unf4), 128'(1'b1));
    clear_err_i = 1; cycle();

    // Reset mid-operation
    push_rd(1); cycle(); push_rd(2); cycle(); push_rd(3); cycle();
    idle(); reset_i = 1; cycle();
    idle(); #1;
    check("rst_outstanding", 128'(outst4), 128'(3'd0));
    cycle();

    // Seven overlapping push/pop pairs to exercise wrap on both depths
    push_rd(0); cycle(); push_rd(1); cycle();
    for (int i = 0; i < 7; i++) begin
      push_rd((i + 2) % 4); rvalid_i = 1; rdata_i = 32'h100 + 32'(i); cycle();
    end
    for (int i = 0; i < 3; i++) begin resp(32'h200 + 32'(i)); cycle(); end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      idle();
      req_i        = ($urandom_range(0, 3) != 0);
      gnt_i        = ($urandom_range(0, 3) != 0);
      master_idx_i = 2'($urandom_range(0, 3));
      wen_i        = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      rvalid_i     = ($urandom_range(0, 1) != 0);
      rdata_i      = $urandom;
      rready_i     = 4'($urandom) | 4'($urandom);
      clear_err_i  = ($urandom_range(0, 15) == 0);
      reset_i      = ($urandom_range(0, 63) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
